// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with writeback bypass, load-use bubble and ID/EX register.
module id_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     id_pc,
  input  logic            flush,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_alu_src_imm,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jalr,
  output logic            ex_pc_src_a,
  output logic            ex_illegal
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic [31:0]     i_imm, s_imm, b_imm, j_imm, u_imm, imm;
  logic [3:0]      fn_op, alu_op;
  logic            src_imm, mr, mw, rw, br, jmp, jr, pca, ill, use1, use2, hazard, live;
  logic [XLEN-1:0] op1, op2;
  logic [12:0]     ctl, ctl_q;
  assign opc       = id_instr[6:0];
  assign f3        = id_instr[14:12];
  assign rs1       = id_instr[19:15];
  assign rs2       = id_instr[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign i_imm = {{20{id_instr[31]}}, id_instr[31:20]};
  assign s_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign b_imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
  assign j_imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
  assign u_imm = {id_instr[31:12], 12'b0};
  always_comb begin
    case (f3)
      3'd0:    fn_op = 4'd0;
      3'd1:    fn_op = 4'd2;
      3'd2:    fn_op = 4'd3;
      3'd3:    fn_op = 4'd4;
      3'd4:    fn_op = 4'd5;
      3'd5:    fn_op = id_instr[30] ? 4'd7 : 4'd6;
      3'd6:    fn_op = 4'd8;
      default: fn_op = 4'd9;
    endcase
  end
  always_comb begin
    {alu_op, src_imm, mr, mw, rw, br, jmp, jr, pca, ill} = '0;
    imm = '0;
    case (opc)
      OP_R:     begin rw = 1'b1; alu_op = (f3 == 3'd0 && id_instr[30]) ? 4'd1 : fn_op; end
      OP_I:     begin src_imm = 1'b1; rw = 1'b1; alu_op = fn_op; imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, id_instr[24:20]} : i_imm; end
      OP_LD:    begin src_imm = 1'b1; mr = 1'b1; rw = 1'b1; imm = i_imm; end
      OP_ST:    begin src_imm = 1'b1; mw = 1'b1; imm = s_imm; end
      OP_BR:    begin br = 1'b1; alu_op = 4'd1; imm = b_imm; end
      OP_JAL:   begin jmp = 1'b1; rw = 1'b1; imm = j_imm; end
      OP_JALR:  begin jr = 1'b1; src_imm = 1'b1; rw = 1'b1; imm = i_imm; end
      OP_LUI:   begin src_imm = 1'b1; rw = 1'b1; alu_op = 4'd10; imm = u_imm; end
      OP_AUIPC: begin pca = 1'b1; src_imm = 1'b1; rw = 1'b1; imm = u_imm; end
      default:  ill = 1'b1;
    endcase
  end
  assign use1   = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign use2   = opc == OP_R || opc == OP_ST || opc == OP_BR;
  assign hazard = ex_valid && ex_mem_read && ex_rd != 5'd0 && id_valid &&
                  ((ex_rd == rs1 && use1) || (ex_rd == rs2 && use2));
  assign stall_if = hazard && !flush;
  assign live     = id_valid && !flush && !hazard;
  // x0 never forwards, so the wb_rd != 0 test is implied by rs != 0
  assign op1 = rs1 == 5'd0 ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_rdata1;
  assign op2 = rs2 == 5'd0 ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_rdata2;
  assign ctl = {alu_op, src_imm, mr, mw, rw, br, jmp, jr, pca, ill};
  assign {ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
          ex_branch, ex_jump, ex_jalr, ex_pc_src_a, ex_illegal} = ctl_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid   <= 1'b0;
      ex_pc      <= RESET_PC;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_imm     <= '0;
      ex_funct3  <= '0;
      ctl_q      <= '0;
    end else begin
      ex_valid   <= live;
      ex_pc      <= id_pc;
      ex_rs1_val <= op1;
      ex_rs2_val <= op2;
      ex_rs1     <= rs1;
      ex_rs2     <= rs2;
      ex_rd      <= id_instr[11:7];
      ex_imm     <= XLEN'($signed(imm));
      ex_funct3  <= f3;
      ctl_q      <= live ? ctl : '0;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: random and directed checks of id_stage against a per-instruction reference model.
module tb_id_stage;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  logic        clk = 1'b0, rstn = 1'b0, id_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0, rf_raddr1, rf_raddr2, ex_rs1, ex_rs2, ex_rd;
  logic        stall_if, ex_valid, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_jalr, ex_pc_src_a, ex_illegal, last_stall;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  int          n_vec = 0, n_err = 0;

  id_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_if(stall_if), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_pc_src_a(ex_pc_src_a), .ex_illegal(ex_illegal));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] imm;
    logic src, mr, mw, rw, br, j, jr, pca, ill, u1, u2;
  } dec_t;
  typedef struct {
    logic v;
    logic [31:0] pc, a, b, imm;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic [3:0] op;
    logic src, mr, mw, rw, br, j, jr, pca, ill;
  } ex_t;
  ex_t m;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_of(logic [2:0] f3, logic b30, logic is_r);
    int lut[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (f3 == 3'd0 && is_r && b30) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd7;
    return 4'(lut[f3]);
  endfunction

  // immediates built arithmetically from the field weights of each format
  function automatic dec_t dec(logic [31:0] x);
    dec_t d;
    int iimm, simm, bimm, jimm;
    d = '{op: 4'd0, imm: 32'd0, default: 1'b0};
    iimm = $signed(x) >>> 20;
    simm = ($signed(x) >>> 25) * 32 + int'(x[11:7]);
    bimm = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
    jimm = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
    d.u1 = 1'b1;
    case (x[6:0])
      7'h33: begin d.rw = 1; d.op = alu_of(x[14:12], x[30], 1'b1); d.u2 = 1; end
      7'h13: begin d.rw = 1; d.src = 1; d.op = alu_of(x[14:12], x[30], 1'b0);
                   d.imm = (x[14:12] == 3'd1 || x[14:12] == 3'd5) ? 32'(x[24:20]) : iimm; end
      7'h03: begin d.mr = 1; d.rw = 1; d.src = 1; d.imm = iimm; end
      7'h23: begin d.mw = 1; d.src = 1; d.imm = simm; d.u2 = 1; end
      7'h63: begin d.br = 1; d.op = 4'd1; d.imm = bimm; d.u2 = 1; end
      7'h6F: begin d.j = 1; d.rw = 1; d.imm = jimm; d.u1 = 0; end
      7'h67: begin d.jr = 1; d.rw = 1; d.src = 1; d.imm = iimm; end
      7'h37: begin d.rw = 1; d.src = 1; d.op = 4'd10; d.imm = x & 32'hFFFF_F000; d.u1 = 0; end
      7'h17: begin d.pca = 1; d.rw = 1; d.src = 1; d.imm = x & 32'hFFFF_F000; d.u1 = 0; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    m = '{v: 1'b0, pc: RESET_PC, a: 32'd0, b: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          f3: 3'd0, op: 4'd0, default: 1'b0};
  endtask

  task automatic check_ex();
    chk("ex_valid", ex_valid, m.v);
    chk("ex_alu_op", ex_alu_op, m.op);
    chk("ex_alu_src_imm", ex_alu_src_imm, m.src);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_branch", ex_branch, m.br);
    chk("ex_jump", ex_jump, m.j);
    chk("ex_jalr", ex_jalr, m.jr);
    chk("ex_pc_src_a", ex_pc_src_a, m.pca);
    chk("ex_illegal", ex_illegal, m.ill);
    if (m.v) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_val", ex_rs1_val, m.a);
      chk("ex_rs2_val", ex_rs2_val, m.b);
      chk("ex_rs1", ex_rs1, m.rs1);
      chk("ex_rs2", ex_rs2, m.rs2);
      chk("ex_rd", ex_rd, m.rd);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_funct3", ex_funct3, m.f3);
    end
  endtask

  task automatic apply(logic v, logic [31:0] ins, logic [31:0] pc, logic fl, logic we,
                       logic [4:0] wrd, logic [31:0] wd, logic [31:0] d1, logic [31:0] d2);
    dec_t d;
    ex_t nx;
    logic [4:0] s1, s2;
    logic hz, live;
    @(negedge clk);
    id_valid = v; id_instr = ins; id_pc = pc; flush = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd; rf_rdata1 = d1; rf_rdata2 = d2;
    #1;
    d = dec(ins);
    s1 = ins[19:15];
    s2 = ins[24:20];
    hz = m.v && m.mr && m.rd != 0 && v && ((m.rd == s1 && d.u1) || (m.rd == s2 && d.u2));
    last_stall = stall_if;
    chk("stall_if", stall_if, hz && !fl);
    chk("rf_raddr1", rf_raddr1, s1);
    chk("rf_raddr2", rf_raddr2, s2);
    live = v && !fl && !hz;
    nx = '{v: live, pc: pc, rs1: s1, rs2: s2, rd: ins[11:7], f3: ins[14:12], imm: d.imm,
           a: s1 == 0 ? 32'd0 : (we && wrd == s1) ? wd : d1,
           b: s2 == 0 ? 32'd0 : (we && wrd == s2) ? wd : d2,
           op: 4'd0, default: 1'b0};
    if (live) begin
      nx.op = d.op; nx.src = d.src; nx.mr = d.mr; nx.mw = d.mw; nx.rw = d.rw;
      nx.br = d.br; nx.j = d.j; nx.jr = d.jr; nx.pca = d.pca; nx.ill = d.ill;
    end
    @(posedge clk);
    #1;
    m = nx;
    check_ex();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
    logic [31:0] x = $urandom;
    x[6:0]   = ops[$urandom_range(0, 10)];
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  function automatic logic [31:0] beq_ins(logic [12:0] off, logic [4:0] r2, logic [4:0] r1);
    return {off[12], off[10:5], r2, r1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  localparam logic [31:0] LW_X5   = {12'd0, 5'd2, 3'b010, 5'd5, 7'h03};
  localparam logic [31:0] ADD_651 = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'h33};

  initial begin
    model_reset();
    id_valid = 1'b1;
    id_instr = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    id_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check_ex();
    chk("rst_stall", stall_if, 1'b0);
    chk("rst_pc", ex_pc, RESET_PC);
    chk("rst_imm", ex_imm, 32'd0);
    chk("rst_rs1_val", ex_rs1_val, 32'd0);
    chk("rst_rd", ex_rd, 5'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    apply(1, {12'd5, 5'd0, 3'b000, 5'd1, 7'h13}, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_src", ex_alu_src_imm, 1'b1);
    chk("addi_rd", ex_rd, 5'd1);
    chk("addi_valid", ex_valid, 1'b1);
    apply(1, {7'd0, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33}, 32'h204, 0, 1, 5'd3, 32'hDEAD_BEEF, 32'd0, 32'h1234);
    chk("byp_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    chk("byp_rs2", ex_rs2_val, 32'd0);
    apply(1, {7'd0, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33}, 32'h208, 0, 1, 5'd0, 32'hDEAD_BEEF, 32'h55AA, 32'h1234);
    chk("nobyp_rs1", ex_rs1_val, 32'h55AA);
    apply(1, LW_X5, 32'h20C, 0, 0, 0, 0, 32'h40, 0);
    apply(1, ADD_651, 32'h210, 0, 0, 0, 0, 32'h7, 32'h9);
    chk("lu_stall", last_stall, 1'b1);
    chk("lu_bubble", ex_valid, 1'b0);
    apply(1, ADD_651, 32'h210, 0, 0, 0, 0, 32'h7, 32'h9);
    chk("lu_stall_end", last_stall, 1'b0);
    chk("lu_issue", ex_valid, 1'b1);
    chk("lu_rs1", ex_rs1, 5'd5);
    apply(1, LW_X5, 32'h214, 0, 0, 0, 0, 0, 0);
    apply(1, {20'h12345, 5'd5, 7'h37}, 32'h218, 0, 0, 0, 0, 0, 0);
    chk("lui_nostall", last_stall, 1'b0);
    apply(1, LW_X5, 32'h21C, 0, 0, 0, 0, 0, 0);
    apply(1, ADD_651, 32'h220, 1, 0, 0, 0, 0, 0);
    chk("fl_stall", last_stall, 1'b0);
    chk("fl_valid", ex_valid, 1'b0);
    chk("fl_rw", ex_reg_write, 1'b0);
    apply(1, {12'h403, 5'd8, 3'b101, 5'd7, 7'h13}, 32'h224, 0, 0, 0, 0, 0, 0);
    chk("srai_op", ex_alu_op, 4'd7);
    chk("srai_imm", ex_imm, 32'd3);
    apply(1, beq_ins(13'h1FFC, 5'd2, 5'd1), 32'h228, 0, 0, 0, 0, 0, 0);
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_br", ex_branch, 1'b1);
    apply(1, {25'd0, 7'h7F}, 32'h22C, 0, 0, 0, 0, 0, 0);
    chk("ill_flag", ex_illegal, 1'b1);
    chk("ill_rw", ex_reg_write, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_ex();
        chk("mid_rst_pc", ex_pc, RESET_PC);
        @(posedge clk);
        #3 rstn = 1'b1;
      end
      apply($urandom_range(0, 9) != 0, rnd_instr(), $urandom, $urandom_range(0, 9) == 0,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the 5-stage RV32I pipeline. It takes the IF/ID instruction, drives the register-file read addresses and accepts the combinational read data. A same-cycle writeback bypass covers a register write that lands in the same cycle. It detects load-use hazards, decodes control, and registers everything into the ID/EX pipeline register, with stall and flush support.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, value of ex_pc after reset

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
id_valid  input  1  IF/ID holds a valid instruction
id_instr  input  32  instruction word
id_pc  input  32  instruction PC
flush  input  1  branch/jump redirect from EX; kills the instruction in ID
rf_raddr1  output  5  register-file read address 1 (= id_instr[19:15])
rf_raddr2  output  5  register-file read address 2 (= id_instr[24:20])
rf_rdata1  input  32  register-file read data 1 (signed)
rf_rdata2  input  32  register-file read data 2 (signed)
wb_we  input  1  writeback enable (same signal that drives the regfile)
wb_rd  input  5  writeback destination
wb_data  input  32  writeback data
stall_if  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  ID/EX entry valid
ex_pc  output  32  registered PC
ex_rs1_val, ex_rs2_val  output  32 each  registered operands
ex_rs1, ex_rs2, ex_rd  output  5 each  registered register indices
ex_imm  output  32  sign-extended immediate
ex_alu_op  output  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
ex_funct3  output  3  raw funct3 (branch/load/store width)
ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_pc_src_a, ex_illegal  output  1 each  control bits

Behaviour:
- Reset (rstn low, async): all ex_* outputs = 0, except ex_pc = RESET_PC. stall_if is combinational and reads 0 while reset is held.
- rf_raddr1/2 are combinational from id_instr, independent of id_valid.
- Bypass: if wb_we && wb_rd != 0 && wb_rd == rs1, the operand is wb_data, otherwise rf_rdata1. rs2 uses the same rule. Index 0 always yields 0, regardless of rf data.
- Decode by opcode:
  - R 0110011: reg_write, alu_op from funct3/funct7[5].
  - I-ALU 0010011: alu_src_imm, I-imm. SRAI is selected by funct7[5].
  - LOAD 0000011: mem_read, reg_write, ADD, I-imm.
  - STORE 0100011: mem_write, ADD, S-imm.
  - BRANCH 1100011: branch, SUB, B-imm.
  - JAL 1101111: jump, reg_write, J-imm.
  - JALR 1100111: jalr, reg_write, ADD, I-imm.
  - LUI 0110111: PASSB, U-imm.
  - AUIPC 0010111: pc_src_a, ADD, U-imm.
  - Any other opcode: ex_illegal = 1 and all write/mem controls = 0.
- rs1/rs2 use flags: rs1 is unused for LUI/AUIPC/JAL. rs2 is used only for R, STORE and BRANCH.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd != 0 && id_valid && ((ex_rd == rs1 && rs1 used) || (ex_rd == rs2 && rs2 used)).
  - stall_if = hazard && !flush.
- Next-state at each clk edge, by priority:
  1. flush: ex_valid <= 0 and all control bits <= 0. Data fields are don't-care. stall_if = 0.
  2. hazard: insert a bubble. ex_valid <= 0, controls <= 0, IF/ID is held by the upstream stage. The stall lasts exactly 1 cycle, because the load then leaves EX.
  3. else: ex_* <= decoded values, ex_valid <= id_valid. When id_valid = 0, all controls <= 0.
- The ID/EX register has no enable. It updates every cycle, because bubbles are inserted rather than holding.
- Reset asserted mid-stream clears ID/EX immediately (async). After release, the first edge loads normally.
- Immediates are sign-extended from instr[31]. B/J immediates carry LSB 0. U-imm = {instr[31:12], 12'b0}.

Test Plan:
- Reset: rstn=0 while the decoder sees an ADD -> every ex_* output = 0, ex_pc = RESET_PC, stall_if = 0. After release, ADDI x1,x0,5 produces ex_imm = 5, ex_alu_src_imm = 1, ex_rd = 1, ex_valid = 1 one cycle later.
- Bypass: wb_we=1, wb_rd=3, wb_data=0xDEAD_BEEF, rf_rdata1=0, ADD x4,x3,x0 in ID -> ex_rs1_val = 0xDEAD_BEEF, ex_rs2_val = 0. The same case with wb_rd=0 gives ex_rs1_val = rf_rdata1.
- Load-use: LW x5,0(x2) followed by ADD x6,x5,x1 -> stall_if = 1 for exactly one cycle and ex_valid = 0 (bubble). The ADD then issues with ex_rs1 = 5. LW x5 followed by LUI x5 -> no stall.
- Flush priority: the load-use condition and flush=1 in the same cycle -> stall_if = 0, ex_valid = 0 next cycle, ex_reg_write = 0.
- Decode: SRAI x7,x8,3 -> ex_alu_op = 7, ex_imm = 3. BEQ with offset -4 -> ex_imm = 0xFFFF_FFFC, ex_branch = 1. Opcode 0x7F -> ex_illegal = 1, ex_reg_write = 0.
